cmp64u_minmax_tracker: RTL and testbench
========================================

// Module: cmp64u_minmax_tracker
// PURPOSE
//  Streaming consumer of Cmp64U: tracks running unsigned min and max of 64-bit
//  samples across a frame delimited by in_last, plus first-seen indices and count.
//  Two Cmp64U instances compare in_data against the stored min and the stored max.
//  Valid/ready on both sides; frame result held until the downstream accepts it.
// PARAMETERS
//  CNT_W     16  width of sample index/count registers
//  TIE_FIRST 1   1: equal sample keeps the earlier index; 0: equal sample takes the newer index
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      sample valid
//  in_ready     out  1      block accepts a sample this cycle
//  in_data      in   64     unsigned sample
//  in_last      in   1      sample is the final beat of the frame
//  out_valid    out  1      frame result valid
//  out_ready    in   1      downstream accepts the result
//  out_min      out  64     smallest sample in the frame
//  out_max      out  64     largest sample in the frame
//  out_min_idx  out  CNT_W  beat index of out_min (0-based)
//  out_max_idx  out  CNT_W  beat index of out_max (0-based)
//  out_count    out  CNT_W  number of beats in the frame (saturating)
//  out_ovf      out  1      frame exceeded 2^CNT_W-1 beats
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, in_ready=0, out_valid=0, every data output
//   and internal register = 0. in_ready is registered and rises on the first clock
//   edge after rst_n deasserts.
//  Compare codes from Cmp64U: 2'b01 op1>op2, 2'b10 op1<op2, 2'b11 equal;
//   op1=in_data, op2=stored min (or max).
//  Beat accepted = in_valid & in_ready. States:
//   IDLE: in_ready=1, out_valid=0. An accepted beat loads min=max=in_data,
//    min_idx=max_idx=0, count=1, ovf=0. in_last=0 -> ACC. in_last=1 -> HOLD.
//   ACC: in_ready=1. An accepted beat uses idx=count (the current count value).
//    Min path: LT -> min<=in_data, min_idx<=idx. EQ and TIE_FIRST=0 -> min_idx<=idx.
//    Max path: GT -> max<=in_data, max_idx<=idx. EQ and TIE_FIRST=0 -> max_idx<=idx.
//    count<=count+1, saturating at 2^CNT_W-1. A beat arriving when count is already
//    saturated sets ovf=1 (sticky) and uses idx=2^CNT_W-1. in_last=1 -> HOLD.
//   HOLD: in_ready=0, out_valid=1, and all out_* hold stable.
//    out_valid & out_ready -> IDLE.
//  Latency: out_valid rises on the clock edge that accepts the in_last beat, so it is
//   visible in the next cycle. in_ready returns to 1 in the cycle after the out
//   handshake. Minimum frame period = beats + 1 cycle (out_ready held high).
//  out_* are the tracking registers themselves. Their values are valid only while
//   out_valid=1 and are don't-care otherwise.
//  in_valid with in_ready=0 is not consumed; upstream holds the data.
//  in_data/in_last are ignored when in_valid=0. No bubbles are required.
//  Single-beat frame: min=max=sample, both indices 0, count=1.
//  Equal samples only: min=max, indices follow TIE_FIRST.
//  Reset asserted mid-frame or in HOLD: the frame is discarded, with no partial output.
// TESTING
//  T1 reset: rst_n=0 for 3 cycles -> in_ready=0, out_valid=0, out_*=0; release -> in_ready=1 next edge
//  T2 frame {5,2,9,2,7} last on 7 -> out_min=2 idx=1, out_max=9 idx=2, count=5, ovf=0;
//     with TIE_FIRST=0 -> out_min_idx=3
//  T3 extremes {64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000} -> min=0 idx=1,
//     max=all-ones idx=0 (checks Cmp64U MSB path)
//  T4 backpressure: out_ready=0 for 10 cycles after a 1-beat frame {42} -> out_valid held,
//     in_ready=0, outputs stable; next frame accepted only after handshake
//  T5 CNT_W=4: 17-beat frame ascending 1..17 -> count=15, ovf=1, max=17 idx=15, min=1 idx=0
//  T6 rst_n pulsed low during beat 3 of {4,3,2,1} -> no out_valid; next frame {8} -> min=max=8, count=1

Source files
------------

// File: rtl/cmp64u_minmax_tracker.sv
// ---------------------------------------------------------------------------
// cmp64u_minmax_tracker
//   Streaming tracker of the running unsigned minimum and maximum of 64-bit
//   samples across a frame delimited by in_last. Also records the first-seen
//   (or last-seen, per TIE_FIRST) beat index of each extreme and the number of
//   beats in the frame. The frame result is held until the downstream accepts it.
//
//   Contains cmp64u, a 64-bit unsigned magnitude comparator. Two instances of it
//   compare in_data against the stored min and the stored max.
//
// Parameters
//   CNT_W      width of beat index / count registers
//   TIE_FIRST  1: equal sample keeps earlier index, 0: equal sample takes newer
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      sample valid
//   in_ready     out  1      block accepts a sample this cycle (registered)
//   in_data      in   64     unsigned sample
//   in_last      in   1      final beat of the frame
//   out_valid    out  1      frame result valid
//   out_ready    in   1      downstream accepts the result
//   out_min      out  64     smallest sample in the frame
//   out_max      out  64     largest sample in the frame
//   out_min_idx  out  CNT_W  beat index of out_min
//   out_max_idx  out  CNT_W  beat index of out_max
//   out_count    out  CNT_W  beats in the frame (saturating)
//   out_ovf      out  1      frame exceeded 2^CNT_W-1 beats
// ---------------------------------------------------------------------------

// cmp64u: code 2'b01 op1>op2, 2'b10 op1<op2, 2'b11 equal.
module cmp64u (
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    output logic [1:0]  code
);
    logic hi_gt, hi_lt, hi_eq, lo_gt, lo_lt;
    logic gt, lt;

    // Split into halves so the upper word decides unless it is equal.
    assign hi_gt = op1[63:32] > op2[63:32];
    assign hi_lt = op1[63:32] < op2[63:32];
    assign hi_eq = op1[63:32] == op2[63:32];
    assign lo_gt = op1[31:0] > op2[31:0];
    assign lo_lt = op1[31:0] < op2[31:0];

    assign gt = hi_gt | (hi_eq & lo_gt);
    assign lt = hi_lt | (hi_eq & lo_lt);

    always_comb begin
        code = 2'b11;
        if (gt)
            code = 2'b01;
        else if (lt)
            code = 2'b10;
    end
endmodule

// State table
//   state | meaning
//   IDLE  | waiting for the first beat of a frame
//   ACC   | accumulating beats of the current frame
//   HOLD  | frame result presented, waiting for out_ready
module cmp64u_minmax_tracker #(
    parameter int CNT_W     = 16,
    parameter bit TIE_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_min,
    output logic [63:0]      out_max,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0]       CMP_GT  = 2'b01;
    localparam logic [1:0]       CMP_LT  = 2'b10;
    localparam logic [1:0]       CMP_EQ  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [63:0]      min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       code_min, code_max;
    logic             accept, sat;

    cmp64u u_cmp_min (.op1(in_data), .op2(min_q), .code(code_min));
    cmp64u u_cmp_max (.op1(in_data), .op2(max_q), .code(code_max));

    assign accept = in_valid & rdy_q;
    // Once saturated the count equals 2^CNT_W-1, which is also the index used.
    assign sat    = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    min_d     = in_data;
                    max_d     = in_data;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    cnt_d     = CNT_ONE;
                    ovf_d     = 1'b0;
                    state_d   = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    if (code_min == CMP_LT) begin
                        min_d     = in_data;
                        min_idx_d = cnt_q;
                    end else if (code_min == CMP_EQ && !TIE_FIRST) begin
                        min_idx_d = cnt_q;
                    end
                    if (code_max == CMP_GT) begin
                        max_d     = in_data;
                        max_idx_d = cnt_q;
                    end else if (code_max == CMP_EQ && !TIE_FIRST) begin
                        max_idx_d = cnt_q;
                    end
                    if (sat)
                        ovf_d = 1'b1;
                    else
                        cnt_d = cnt_q + CNT_ONE;
                    if (in_last)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered: low through reset, up on the first edge after it.
    assign rdy_d = (state_d != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (state_q == HOLD);
    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
    assign out_count   = cnt_q;
    assign out_ovf     = ovf_q;
endmodule

// File: tb/tb_cmp64u_minmax_tracker.sv
module tb_cmp64u_minmax_tracker;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_last, out_ready;
    logic [63:0] in_data;

    always #5 clk = ~clk;

    // a: defaults, b: TIE_FIRST=0, c: CNT_W=4. All share the same stimulus.
    logic        a_rdy, a_ov, a_ovf;
    logic [63:0] a_min, a_max;
    logic [15:0] a_mni, a_mxi, a_cnt;
    logic        b_rdy, b_ov, b_ovf;
    logic [63:0] b_min, b_max;
    logic [15:0] b_mni, b_mxi, b_cnt;
    logic        c_rdy, c_ov, c_ovf;
    logic [63:0] c_min, c_max;
    logic [3:0]  c_mni, c_mxi, c_cnt;

    cmp64u_minmax_tracker u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_rdy),
        .in_data(in_data), .in_last(in_last), .out_valid(a_ov), .out_ready(out_ready),
        .out_min(a_min), .out_max(a_max), .out_min_idx(a_mni), .out_max_idx(a_mxi),
        .out_count(a_cnt), .out_ovf(a_ovf));

    cmp64u_minmax_tracker #(.CNT_W(16), .TIE_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_rdy),
        .in_data(in_data), .in_last(in_last), .out_valid(b_ov), .out_ready(out_ready),
        .out_min(b_min), .out_max(b_max), .out_min_idx(b_mni), .out_max_idx(b_mxi),
        .out_count(b_cnt), .out_ovf(b_ovf));

    cmp64u_minmax_tracker #(.CNT_W(4), .TIE_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_rdy),
        .in_data(in_data), .in_last(in_last), .out_valid(c_ov), .out_ready(out_ready),
        .out_min(c_min), .out_max(c_max), .out_min_idx(c_mni), .out_max_idx(c_mxi),
        .out_count(c_cnt), .out_ovf(c_ovf));

    int errors = 0;
    int checks = 0;
    logic [63:0] beats [0:31];

    typedef struct {
        int          n;
        logic [63:0] d [0:4];
        logic [63:0] mn, mx;
        int          mn_i, mx_i;    // TIE_FIRST=1
        int          mn_i0, mx_i0;  // TIE_FIRST=0
    } vec_t;

    vec_t vecs [0:5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; on return the last beat has been accepted.
    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (!a_rdy && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!a_rdy) chk("in_ready_wait", 64'd0, 64'd1);
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("latency_out_valid", {63'd0, a_ov}, 64'd1);
        chk("hold_in_ready", {63'd0, a_rdy}, 64'd0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", {63'd0, a_ov}, 64'd0);
        chk("post_hs_in_ready", {63'd0, a_rdy}, 64'd1);
    endtask

    initial begin
        vecs[0] = '{n: 5, d: '{64'd5, 64'd2, 64'd9, 64'd2, 64'd7},
                    mn: 64'd2, mx: 64'd9, mn_i: 1, mx_i: 2, mn_i0: 3, mx_i0: 2};
        vecs[1] = '{n: 3, d: '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd0},
                    mn: 64'd0, mx: 64'hFFFF_FFFF_FFFF_FFFF, mn_i: 1, mx_i: 0, mn_i0: 1, mx_i0: 0};
        vecs[2] = '{n: 1, d: '{64'd42, 64'd0, 64'd0, 64'd0, 64'd0},
                    mn: 64'd42, mx: 64'd42, mn_i: 0, mx_i: 0, mn_i0: 0, mx_i0: 0};
        vecs[3] = '{n: 3, d: '{64'd7, 64'd7, 64'd7, 64'd0, 64'd0},
                    mn: 64'd7, mx: 64'd7, mn_i: 0, mx_i: 0, mn_i0: 2, mx_i0: 2};
        vecs[4] = '{n: 5, d: '{64'd3, 64'd10, 64'd10, 64'd1, 64'd1},
                    mn: 64'd1, mx: 64'd10, mn_i: 3, mx_i: 1, mn_i0: 4, mx_i0: 2};
        vecs[5] = '{n: 4, d: '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF,
                               64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'd0},
                    mn: 64'h0000_0000_FFFF_FFFF, mx: 64'h8000_0000_0000_0001,
                    mn_i: 1, mx_i: 2, mn_i0: 1, mx_i0: 2};

        // T1 reset
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {61'd0, a_rdy, b_rdy, c_rdy}, 64'd0);
        chk("rst_out_valid", {61'd0, a_ov, b_ov, c_ov}, 64'd0);
        chk("rst_min", a_min | b_min | c_min, 64'd0);
        chk("rst_max", a_max | b_max | c_max, 64'd0);
        chk("rst_idx_cnt", {16'd0, a_mni | b_mni, a_mxi | b_mxi, a_cnt | b_cnt}, 64'd0);
        chk("rst_ovf", {61'd0, a_ovf, b_ovf, c_ovf}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", {63'd0, a_rdy}, 64'd0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", {61'd0, a_rdy, b_rdy, c_rdy}, 64'd7);

        // T5 saturation: 17 ascending beats
        for (int i = 0; i < 17; i++) beats[i] = 64'(i + 1);
        send_frame(17);
        chk("t5_w4_count", {60'd0, c_cnt}, 64'd15);
        chk("t5_w4_ovf", {63'd0, c_ovf}, 64'd1);
        chk("t5_w4_max", c_max, 64'd17);
        chk("t5_w4_max_idx", {60'd0, c_mxi}, 64'd15);
        chk("t5_w4_min", c_min, 64'd1);
        chk("t5_w4_min_idx", {60'd0, c_mni}, 64'd0);
        chk("t5_w16_count", {48'd0, a_cnt}, 64'd17);
        chk("t5_w16_ovf", {63'd0, a_ovf}, 64'd0);
        chk("t5_w16_max_idx", {48'd0, a_mxi}, 64'd16);
        handshake();

        // Table-driven frames (T2, T3 and more)
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) beats[i] = vecs[v].d[i];
            send_frame(vecs[v].n);
            chk($sformatf("v%0d_min", v), a_min, vecs[v].mn);
            chk($sformatf("v%0d_max", v), a_max, vecs[v].mx);
            chk($sformatf("v%0d_min_idx", v), {48'd0, a_mni}, 64'(vecs[v].mn_i));
            chk($sformatf("v%0d_max_idx", v), {48'd0, a_mxi}, 64'(vecs[v].mx_i));
            chk($sformatf("v%0d_count", v), {48'd0, a_cnt}, 64'(vecs[v].n));
            chk($sformatf("v%0d_ovf", v), {62'd0, a_ovf, c_ovf}, 64'd0);
            chk($sformatf("v%0d_t0_min", v), b_min, vecs[v].mn);
            chk($sformatf("v%0d_t0_max", v), b_max, vecs[v].mx);
            chk($sformatf("v%0d_t0_min_idx", v), {48'd0, b_mni}, 64'(vecs[v].mn_i0));
            chk($sformatf("v%0d_t0_max_idx", v), {48'd0, b_mxi}, 64'(vecs[v].mx_i0));
            chk($sformatf("v%0d_w4_count", v), {60'd0, c_cnt}, 64'(vecs[v].n));
            handshake();
        end

        // T4 backpressure on a 1-beat frame, with a waiting sample upstream
        beats[0] = 64'd42;
        send_frame(1);
        in_valid = 1'b1; in_data = 64'd99; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_hold_ov_%0d", i), {63'd0, a_ov}, 64'd1);
            chk($sformatf("t4_hold_rdy_%0d", i), {63'd0, a_rdy}, 64'd0);
            chk($sformatf("t4_hold_min_%0d", i), a_min, 64'd42);
            chk($sformatf("t4_hold_max_%0d", i), a_max, 64'd42);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_after_hs_ov", {63'd0, a_ov}, 64'd0);
        chk("t4_after_hs_rdy", {63'd0, a_rdy}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("t4_next_ov", {63'd0, a_ov}, 64'd1);
        chk("t4_next_min", a_min, 64'd99);
        chk("t4_next_count", {48'd0, a_cnt}, 64'd1);
        handshake();

        // T6 reset in the middle of a frame
        in_valid = 1'b1; in_last = 1'b0; in_data = 64'd4;
        @(negedge clk);
        in_data = 64'd3;
        @(negedge clk);
        in_data = 64'd2;
        #2 rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_rst_ov", {63'd0, a_ov}, 64'd0);
        chk("t6_rst_rdy", {63'd0, a_rdy}, 64'd0);
        chk("t6_rst_count", {48'd0, a_cnt}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6_no_out_%0d", i), {63'd0, a_ov}, 64'd0);
        end
        beats[0] = 64'd8;
        send_frame(1);
        chk("t6_min", a_min, 64'd8);
        chk("t6_max", a_max, 64'd8);
        chk("t6_count", {48'd0, a_cnt}, 64'd1);
        chk("t6_idx", {32'd0, a_mni, a_mxi}, 64'd0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
